// File: rtl/mips_lite_pkg.sv
// Shared types and default widths for the mips_lite hazard unit.
// Tracker entries carry a register address wide enough for any supported RAW.
package mips_lite_pkg;

    localparam int RAW_DEF   = 5;
    localparam int CNT_W_DEF = 32;
    localparam int DST_W     = 8;

    typedef enum logic [1:0] {
        REG_FILE = 2'b00,
        EX_MEM   = 2'b01,
        MEM_WB   = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic [DST_W-1:0] dst;
        logic             wr;
        logic             load;
        logic             halt;
    } trk_entry_t;

endpackage

// File: rtl/mips_lite_src_match.sv
// Hazard detection for one decode source operand against the EX and MEM entries.
// Produces a stall request and the bypass select for that operand.
module mips_lite_src_match
    import mips_lite_pkg::*;
#(
    parameter int RAW      = RAW_DEF,
    parameter int FWD_MODE = 1,
    parameter int R0_ZERO  = 0
) (
    input  logic [RAW-1:0] src,
    input  logic           used,
    input  trk_entry_t     ex_e,
    input  trk_entry_t     mem_e,
    output logic           stall_req,
    output fwd_sel_t       fwd_sel
);

    logic [DST_W-1:0] src_ext;
    logic             live;
    logic             ex_hit;
    logic             mem_hit;
    logic             unused_fields;

    assign unused_fields = ^{ex_e.halt, mem_e.load, mem_e.halt};

    always_comb begin
        src_ext   = DST_W'(src);
        live      = used && !((R0_ZERO != 0) && (src == '0));
        ex_hit    = live && ex_e.valid && ex_e.wr && (ex_e.dst == src_ext);
        mem_hit   = live && mem_e.valid && mem_e.wr && (mem_e.dst == src_ext);
        stall_req = 1'b0;
        fwd_sel   = REG_FILE;
        if (FWD_MODE != 0) begin
            // A load in EX has no result yet, and an older MEM value would be stale.
            if (ex_hit) begin
                if (ex_e.load) begin
                    stall_req = 1'b1;
                end else begin
                    fwd_sel = EX_MEM;
                end
            end else if (mem_hit) begin
                fwd_sel = MEM_WB;
            end
        end else begin
            stall_req = ex_hit || mem_hit;
        end
    end

endmodule

// File: rtl/mips_lite_hazard_unit.sv
// Stall/flush/forwarding control for a 5-stage MIPS-lite pipeline, with a
// three-entry in-flight tracker, sticky HALT handling and saturating statistics.
module mips_lite_hazard_unit
    import mips_lite_pkg::*;
#(
    parameter int RAW      = RAW_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int FWD_MODE = 1,
    parameter int R0_ZERO  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RAW-1:0]   id_rs,
    input  logic [RAW-1:0]   id_rt,
    input  logic [1:0]       id_use,
    input  logic [RAW-1:0]   id_dst,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             id_halt,
    input  logic             ex_br_taken,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rt,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_instr,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_branch
);

    trk_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_rec;
    logic       halt_seen_q, halt_seen_d;
    logic       halted_q, halted_d;
    logic       flush_q, flush_d;
    logic       id_live;
    logic [1:0] src_stall;
    fwd_sel_t   src_fwd [2];
    logic [RAW-1:0] id_src [2];
    logic [3:0] cnt_inc;
    logic [3:0][CNT_W-1:0] cnt_all;
    logic       unused_wb;

    assign unused_wb = ^{wb_q.dst, wb_q.wr, wb_q.load};

    // The slot right after a taken branch is the squashed fetch, so it is not live either.
    assign id_live   = id_valid && !reset && !flush_q && !halt_seen_q;
    assign id_src[0] = id_rs;
    assign id_src[1] = id_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            mips_lite_src_match #(
                .RAW      (RAW),
                .FWD_MODE (FWD_MODE),
                .R0_ZERO  (R0_ZERO)
            ) u_match (
                .src       (id_src[gi]),
                .used      (id_live && id_use[gi]),
                .ex_e      (ex_q),
                .mem_e     (mem_q),
                .stall_req (src_stall[gi]),
                .fwd_sel   (src_fwd[gi])
            );
        end
    endgenerate

    assign fwd_rs = src_fwd[0];
    assign fwd_rt = src_fwd[1];
    assign halted = halted_q;

    always_comb begin
        flush  = ex_br_taken && ex_q.valid && !reset;
        stall  = (|src_stall) && !flush;
        id_rec = '{valid: 1'b1, dst: DST_W'(id_dst), wr: id_wr, load: id_load, halt: id_halt};

        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q;
        flush_d     = flush_q;
        if (!halted_q) begin
            ex_d = '0;
            if (id_live && !stall && !flush) begin
                ex_d = id_rec;
            end
            mem_d       = ex_q;
            wb_d        = mem_q;
            halt_seen_d = halt_seen_q || (ex_d.valid && ex_d.halt);
            halted_d    = wb_q.valid && wb_q.halt;
            flush_d     = flush;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
            flush_q     <= flush_d;
        end
    end

    // Counter order: cycle, retired instruction, stall, taken branch.
    assign cnt_inc = {flush, stall, wb_q.valid, 1'b1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (!halted_q && cnt_inc[gi] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    assign cnt_cycle  = cnt_all[0];
    assign cnt_instr  = cnt_all[1];
    assign cnt_stall  = cnt_all[2];
    assign cnt_branch = cnt_all[3];

endmodule
